mouse_position_tracker: RTL and testbench



---
 rtl/mouse_pkg.sv | 56 +++++
 rtl/mouse_axis_clamp.sv | 30 +++
 rtl/mouse_position_tracker.sv | 231 +++++++++++++++++++++++
 tb/tb_mouse_position_tracker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared types, constants and delta-building helpers for the mouse position tracker.
// Deltas are carried as DW-bit signed values so gain and clamping never overflow.
package mouse_pkg;

    localparam int DW = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCALE   = 2'd1,
        UPDATE  = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    localparam int STATUS_LEFT   = 0;
    localparam int STATUS_RIGHT  = 1;
    localparam int STATUS_MIDDLE = 2;
    localparam int STATUS_X_SIGN = 4;
    localparam int STATUS_Y_SIGN = 5;
    localparam int STATUS_X_OVF  = 6;
    localparam int STATUS_Y_OVF  = 7;

    localparam logic [1:0] DPI_HALF = 2'd0;
    localparam logic [1:0] DPI_X1   = 2'd1;
    localparam logic [1:0] DPI_X2   = 2'd2;
    localparam logic [1:0] DPI_X4   = 2'd3;

    // An overflowed axis saturates to the extreme 9-bit value in its sign direction.
    function automatic logic signed [DW-1:0] build_delta(
        input logic       sign,
        input logic       ovf,
        input logic [7:0] mag
    );
        logic [8:0] d9;
        if (ovf) begin
            d9 = sign ? 9'h100 : 9'h0FF;
        end else begin
            d9 = {sign, mag};
        end
        return {{(DW-9){d9[8]}}, d9};
    endfunction

    function automatic logic signed [DW-1:0] apply_dpi(
        input logic signed [DW-1:0] d,
        input logic [1:0]           dpi
    );
        logic signed [DW-1:0] r;
        case (dpi)
            DPI_HALF: r = d >>> 1;
            DPI_X2:   r = d <<< 1;
            DPI_X4:   r = d <<< 2;
            default:  r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// Signed add of a position and a delta, saturated into [MIN, MAX].
// Purely combinational; one instance per axis.
module mouse_axis_clamp
    import mouse_pkg::*;
#(
    parameter int MIN = 0,
    parameter int MAX = 255
)(
    input  logic signed [DW-1:0] current,
    input  logic signed [DW-1:0] delta,
    output logic [7:0]           clamped
);

    localparam logic signed [DW:0] MIN_S = (DW+1)'(MIN);
    localparam logic signed [DW:0] MAX_S = (DW+1)'(MAX);

    logic signed [DW:0] sum;

    always_comb begin
        sum = $signed({current[DW-1], current}) + $signed({delta[DW-1], delta});
        if (sum < MIN_S) begin
            clamped = MIN_S[7:0];
        end else if (sum > MAX_S) begin
            clamped = MAX_S[7:0];
        end else begin
            clamped = sum[7:0];
        end
    end

endmodule

// File: rtl/mouse_position_tracker.sv
// Turns decoded IntelliMouse packets into bounded absolute X/Y, a wheel count and button status.
// Four-state pipeline with a one-entry, newest-wins pending buffer for packets that arrive while busy.
module mouse_position_tracker
    import mouse_pkg::*;
#(
    parameter int X_LIMIT = 160,
    parameter int Y_LIMIT = 120,
    parameter int X_INIT  = 80,
    parameter int Y_INIT  = 60
)(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       INITIALIZED,
    input  logic       PACKET_VALID,
    input  logic [7:0] STATUS,
    input  logic [7:0] DX,
    input  logic [7:0] DY,
    input  logic [7:0] DZ,
    input  logic [1:0] DPI,
    output logic [7:0] MouseX,
    output logic [7:0] MouseY,
    output logic [7:0] MouseZ,
    output logic [3:0] MouseStatus,
    output logic       SendInterrupt
);

    state_t state;
    state_t next_state;

    logic       pending_valid;
    logic [7:0] pending_status;
    logic [7:0] pending_dx;
    logic [7:0] pending_dy;
    logic [7:0] pending_dz;

    logic [7:0] work_status;
    logic [7:0] work_dx;
    logic [7:0] work_dy;
    logic [7:0] work_dz;

    logic signed [DW-1:0] delta_x;
    logic signed [DW-1:0] delta_y;
    logic signed [DW-1:0] delta_z;

    logic [7:0] next_x;
    logic [7:0] next_y;
    logic [7:0] next_z;
    logic [7:0] clamp_x;
    logic [7:0] clamp_y;
    logic [7:0] clamp_z;

    logic signed [DW-1:0] current_x;
    logic signed [DW-1:0] current_y;
    logic signed [DW-1:0] current_z;

    logic       initialized_q;
    logic [2:0] buttons_q;
    logic       send_irq_q;

    logic accept_packet;
    logic load_work;
    logic do_scale;
    logic do_update;
    logic do_publish;

    logic unused_bits;

    assign accept_packet = PACKET_VALID && INITIALIZED;
    assign unused_bits   = ^{work_status[3], work_dz[7:4]};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping INITIALIZED abandons any packet in flight so positions hold.
    always_comb begin
        next_state = state;
        if (!INITIALIZED) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (pending_valid || PACKET_VALID) next_state = SCALE;
                SCALE:   next_state = UPDATE;
                UPDATE:  next_state = PUBLISH;
                PUBLISH: next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        load_work  = 1'b0;
        do_scale   = 1'b0;
        do_update  = 1'b0;
        do_publish = 1'b0;
        if (INITIALIZED) begin
            case (state)
                IDLE:    load_work  = pending_valid || PACKET_VALID;
                SCALE:   do_scale   = 1'b1;
                UPDATE:  do_update  = 1'b1;
                PUBLISH: do_publish = 1'b1;
                default: ;
            endcase
        end
    end

    // A new packet lands in pending whenever it cannot go straight to the work registers.
    always_ff @(posedge CLK) begin
        if (RESET || !INITIALIZED) begin
            pending_valid  <= 1'b0;
            pending_status <= '0;
            pending_dx     <= '0;
            pending_dy     <= '0;
            pending_dz     <= '0;
        end else if (accept_packet && (state != IDLE || pending_valid)) begin
            pending_valid  <= 1'b1;
            pending_status <= STATUS;
            pending_dx     <= DX;
            pending_dy     <= DY;
            pending_dz     <= DZ;
        end else if (load_work && pending_valid) begin
            pending_valid  <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            work_status <= '0;
            work_dx     <= '0;
            work_dy     <= '0;
            work_dz     <= '0;
        end else if (load_work) begin
            if (pending_valid) begin
                work_status <= pending_status;
                work_dx     <= pending_dx;
                work_dy     <= pending_dy;
                work_dz     <= pending_dz;
            end else begin
                work_status <= STATUS;
                work_dx     <= DX;
                work_dy     <= DY;
                work_dz     <= DZ;
            end
        end
    end

    // DPI is only looked at here, so a mid-packet change affects later packets only.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            delta_x <= '0;
            delta_y <= '0;
            delta_z <= '0;
        end else if (do_scale) begin
            delta_x <= apply_dpi(build_delta(work_status[STATUS_X_SIGN],
                                             work_status[STATUS_X_OVF], work_dx), DPI);
            delta_y <= apply_dpi(build_delta(work_status[STATUS_Y_SIGN],
                                             work_status[STATUS_Y_OVF], work_dy), DPI);
            delta_z <= {{(DW-4){work_dz[3]}}, work_dz[3:0]};
        end
    end

    assign current_x = {{(DW-8){1'b0}}, MouseX};
    assign current_y = {{(DW-8){1'b0}}, MouseY};
    assign current_z = {{(DW-8){1'b0}}, MouseZ};

    mouse_axis_clamp #(.MIN(0), .MAX(X_LIMIT - 1)) u_clamp_x (
        .current (current_x),
        .delta   (delta_x),
        .clamped (clamp_x)
    );

    mouse_axis_clamp #(.MIN(0), .MAX(Y_LIMIT - 1)) u_clamp_y (
        .current (current_y),
        .delta   (delta_y),
        .clamped (clamp_y)
    );

    mouse_axis_clamp #(.MIN(0), .MAX(255)) u_clamp_z (
        .current (current_z),
        .delta   (delta_z),
        .clamped (clamp_z)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            next_x <= 8'(X_INIT);
            next_y <= 8'(Y_INIT);
            next_z <= '0;
        end else if (do_update) begin
            next_x <= clamp_x;
            next_y <= clamp_y;
            next_z <= clamp_z;
        end
    end

    // All visible outputs change together with the interrupt pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            MouseX     <= 8'(X_INIT);
            MouseY     <= 8'(Y_INIT);
            MouseZ     <= '0;
            buttons_q  <= '0;
            send_irq_q <= 1'b0;
        end else begin
            send_irq_q <= do_publish;
            if (do_publish) begin
                MouseX    <= next_x;
                MouseY    <= next_y;
                MouseZ    <= next_z;
                buttons_q <= {work_status[STATUS_LEFT], work_status[STATUS_MIDDLE],
                              work_status[STATUS_RIGHT]};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            initialized_q <= 1'b0;
        end else begin
            initialized_q <= INITIALIZED;
        end
    end

    assign MouseStatus   = {initialized_q, buttons_q};
    assign SendInterrupt = send_irq_q;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed bench for mouse_position_tracker with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are read at the same point.
module tb_mouse_position_tracker;

    logic       clk;
    logic       reset;
    logic       initialized;
    logic       packet_valid;
    logic [7:0] status;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [7:0] dz;
    logic [1:0] dpi;
    logic [7:0] mouse_x;
    logic [7:0] mouse_y;
    logic [7:0] mouse_z;
    logic [3:0] mouse_status;
    logic       send_interrupt;

    int checks    = 0;
    int failures  = 0;
    int irq_count = 0;
    int base;
    int lat;

    mouse_position_tracker dut (
        .CLK           (clk),
        .RESET         (reset),
        .INITIALIZED   (initialized),
        .PACKET_VALID  (packet_valid),
        .STATUS        (status),
        .DX            (dx),
        .DY            (dy),
        .DZ            (dz),
        .DPI           (dpi),
        .MouseX        (mouse_x),
        .MouseY        (mouse_y),
        .MouseZ        (mouse_z),
        .MouseStatus   (mouse_status),
        .SendInterrupt (send_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (send_interrupt === 1'b1) irq_count++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] s, input logic [7:0] x,
                                  input logic [7:0] y, input logic [7:0] z);
        status       = s;
        dx           = x;
        dy           = y;
        dz           = z;
        packet_valid = 1'b1;
        tick();
        packet_valid = 1'b0;
    endtask

    task automatic wait_irq(output int latency);
        logic found;
        found   = 1'b0;
        latency = 0;
        for (int i = 0; i < 8; i++) begin
            if (send_interrupt === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
            latency++;
        end
        check_output("irq_seen", {15'd0, found}, 16'd1);
    endtask

    task automatic send_packet(input logic [7:0] s, input logic [7:0] x,
                               input logic [7:0] y, input logic [7:0] z);
        int l;
        apply_stimulus(s, x, y, z);
        wait_irq(l);
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        initialized  = 1'b0;
        packet_valid = 1'b0;
        status       = '0;
        dx           = '0;
        dy           = '0;
        dz           = '0;
        dpi          = 2'd1;
        tick();
        tick();
        check_output("reset_x", 16'(mouse_x), 16'd80);
        check_output("reset_y", 16'(mouse_y), 16'd60);
        check_output("reset_z", 16'(mouse_z), 16'd0);
        check_output("reset_status", 16'(mouse_status), 16'd0);
        check_output("reset_irq", 16'(send_interrupt), 16'd0);
        reset       = 1'b0;
        initialized = 1'b1;
        tick();
        tick();

        $display("[TB] basic packet");
        base = irq_count;
        apply_stimulus(8'h08, 8'h0A, 8'h05, 8'h00);
        wait_irq(lat);
        check_output("latency", 16'(lat), 16'd3);
        check_output("basic_x", 16'(mouse_x), 16'd90);
        check_output("basic_y", 16'(mouse_y), 16'd65);
        check_output("basic_z", 16'(mouse_z), 16'd0);
        check_output("basic_status", 16'(mouse_status), 16'b1000);
        tick();
        check_output("irq_width", 16'(send_interrupt), 16'd0);
        repeat (4) tick();
        check_output("basic_irq_count", 16'(irq_count - base), 16'd1);

        $display("[TB] dpi gain");
        dpi = 2'd3;
        send_packet(8'h18, 8'hFF, 8'h00, 8'h00);
        check_output("dpi4_x", 16'(mouse_x), 16'd86);
        check_output("dpi4_y", 16'(mouse_y), 16'd65);
        dpi = 2'd0;
        send_packet(8'h18, 8'hFF, 8'h00, 8'h00);
        check_output("dpi_half_x", 16'(mouse_x), 16'd85);

        $display("[TB] overflow and clamping");
        dpi = 2'd1;
        send_packet(8'h48, 8'h00, 8'h00, 8'h00);
        check_output("ovf_pos_x", 16'(mouse_x), 16'd159);
        send_packet(8'h58, 8'h00, 8'h00, 8'h00);
        check_output("ovf_neg_x", 16'(mouse_x), 16'd0);
        send_packet(8'h88, 8'h00, 8'h00, 8'h00);
        check_output("ovf_pos_y", 16'(mouse_y), 16'd119);
        check_output("ovf_pos_y_x_hold", 16'(mouse_x), 16'd0);
        send_packet(8'hA8, 8'h00, 8'h00, 8'h00);
        check_output("ovf_neg_y", 16'(mouse_y), 16'd0);

        $display("[TB] wheel");
        for (int i = 0; i < 3; i++) send_packet(8'h08, 8'h00, 8'h00, 8'h0F);
        check_output("wheel_floor", 16'(mouse_z), 16'd0);
        for (int i = 0; i < 36; i++) send_packet(8'h08, 8'h00, 8'h00, 8'h07);
        check_output("wheel_252", 16'(mouse_z), 16'd252);
        for (int i = 0; i < 4; i++) send_packet(8'h08, 8'h00, 8'h00, 8'hF7);
        check_output("wheel_ceiling", 16'(mouse_z), 16'd255);

        $display("[TB] buttons");
        send_packet(8'h0F, 8'h00, 8'h00, 8'h00);
        check_output("buttons_all", 16'(mouse_status), 16'b1111);

        $display("[TB] back-to-back strobes");
        base = irq_count;
        apply_stimulus(8'h09, 8'h01, 8'h00, 8'h00);
        apply_stimulus(8'h0A, 8'h02, 8'h00, 8'h00);
        apply_stimulus(8'h0C, 8'h04, 8'h00, 8'h00);
        wait_irq(lat);
        check_output("b2b_first_x", 16'(mouse_x), 16'd1);
        check_output("b2b_first_status", 16'(mouse_status), 16'b1100);
        tick();
        wait_irq(lat);
        check_output("b2b_drain_latency", 16'(lat), 16'd3);
        check_output("b2b_last_x", 16'(mouse_x), 16'd5);
        check_output("b2b_last_status", 16'(mouse_status), 16'b1010);
        repeat (8) tick();
        check_output("b2b_irq_count", 16'(irq_count - base), 16'd2);

        $display("[TB] reset mid-packet");
        base = irq_count;
        apply_stimulus(8'h0F, 8'h10, 8'h10, 8'h01);
        tick();
        reset = 1'b1;
        tick();
        check_output("abort_x", 16'(mouse_x), 16'd80);
        check_output("abort_y", 16'(mouse_y), 16'd60);
        check_output("abort_z", 16'(mouse_z), 16'd0);
        check_output("abort_status", 16'(mouse_status), 16'd0);
        reset = 1'b0;
        repeat (6) tick();
        check_output("abort_irq_count", 16'(irq_count - base), 16'd0);
        check_output("abort_x_hold", 16'(mouse_x), 16'd80);
        check_output("abort_status_init", 16'(mouse_status), 16'b1000);

        $display("[TB] uninitialized strobe");
        initialized = 1'b0;
        tick();
        check_output("uninit_status", 16'(mouse_status), 16'd0);
        base = irq_count;
        apply_stimulus(8'h08, 8'h05, 8'h05, 8'h00);
        repeat (6) tick();
        check_output("uninit_irq_count", 16'(irq_count - base), 16'd0);
        check_output("uninit_x", 16'(mouse_x), 16'd80);
        initialized = 1'b1;
        tick();
        send_packet(8'h08, 8'h05, 8'h00, 8'h00);
        check_output("reinit_x", 16'(mouse_x), 16'd85);
        check_output("reinit_y", 16'(mouse_y), 16'd60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
